// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// ACK/NACK bus levels and field widths.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int BYTE_W = 8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR       = 3'd1,
      ADDR_ACK   = 3'd2,
      WRITE_BYTE = 3'd3,
      WRITE_ACK  = 3'd4,
      READ_BYTE  = 3'd5,
      READ_ACK   = 3'd6,
      WAIT_STOP  = 3'd7
   } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronisers with registered one-clk SCL edge and
// START/STOP condition pulses, aligned with the synchronised SDA level.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_rise_q;
   logic                   scl_fall_q;
   logic                   start_q;
   logic                   stop_q;
   logic                   scl_new_s;
   logic                   scl_old_s;
   logic                   sda_new_s;
   logic                   sda_old_s;

   // Edges are taken between the last two stages so the pulse lands on the
   // same clk the last stage (exported level) takes the new value.
   assign scl_new_s = scl_sync_q[SYNC_STAGES-2];
   assign scl_old_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_new_s = sda_sync_q[SYNC_STAGES-2];
   assign sda_old_s = sda_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_rise_q <= scl_new_s & ~scl_old_s;
         scl_fall_q <= ~scl_new_s & scl_old_s;
         start_q    <= scl_new_s & scl_old_s & ~sda_new_s & sda_old_s;
         stop_q     <= scl_new_s & scl_old_s & sda_new_s & ~sda_old_s;
      end
   end

   assign sda_o       = sda_old_s;
   assign scl_rise_o  = scl_rise_q;
   assign scl_fall_o  = scl_fall_q;
   assign start_det_o = start_q;
   assign stop_det_o  = stop_q;

endmodule

// File: rtl/i2c_slave_device.sv
// I2C target: fixed 7-bit address, byte-wide write receive and read
// transmit through a parallel port, open-drain SDA, no clock stretching.
module i2c_slave_device
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDRESS     = 7'h42,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl,
   inout  wire               sda,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_req,
   output logic              busy
);

   state_t              state_q;
   logic [2:0]          bit_cnt_q;
   logic [BYTE_W-1:0]   shift_q;
   logic [BYTE_W-1:0]   shift_d;
   logic                rw_q;
   logic                ack_q;
   logic                sda_low_q;
   logic [BYTE_W-1:0]   rx_data_q;
   logic                rx_valid_q;
   logic                tx_req_q;
   logic                busy_q;

   logic                sda_s;
   logic                scl_rise_s;
   logic                scl_fall_s;
   logic                start_det_s;
   logic                stop_det_s;

   i2c_bus_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bus_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .scl_i       (scl),
      .sda_i       (sda),
      .sda_o       (sda_s),
      .scl_rise_o  (scl_rise_s),
      .scl_fall_o  (scl_fall_s),
      .start_det_o (start_det_s),
      .stop_det_o  (stop_det_s)
   );

   assign shift_d = {shift_q[BYTE_W-2:0], sda_s};

   // ack_q is the drive/release phase in ADDR_ACK/WRITE_ACK and the
   // master's ACK flag in READ_ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd7;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         sda_low_q  <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         if (stop_det_s) begin
            state_q   <= IDLE;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
         end else if (start_det_s) begin
            state_q   <= ADDR;
            sda_low_q <= 1'b0;
            bit_cnt_q <= 3'd7;
         end else begin
            case (state_q)
               IDLE: begin
                  sda_low_q <= 1'b0;
               end
               ADDR: begin
                  if (scl_rise_s) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q - 3'd1;
                     if (bit_cnt_q == 3'd0) begin
                        if (shift_q[ADDR_W-1:0] == ADDRESS) begin
                           rw_q    <= sda_s;
                           busy_q  <= 1'b1;
                           ack_q   <= 1'b0;
                           state_q <= ADDR_ACK;
                        end else begin
                           busy_q  <= 1'b0;
                           state_q <= IDLE;
                        end
                     end
                  end
               end
               ADDR_ACK, WRITE_ACK: begin
                  if (scl_fall_s) begin
                     if (!ack_q) begin
                        sda_low_q <= ~I2C_ACK;
                        ack_q     <= 1'b1;
                     end else if ((state_q == ADDR_ACK) && rw_q) begin
                        tx_req_q  <= 1'b1;
                        shift_q   <= tx_data;
                        sda_low_q <= ~tx_data[BYTE_W-1];
                        bit_cnt_q <= 3'd7;
                        state_q   <= READ_BYTE;
                     end else begin
                        sda_low_q <= 1'b0;
                        bit_cnt_q <= 3'd7;
                        state_q   <= WRITE_BYTE;
                     end
                  end
               end
               WRITE_BYTE: begin
                  if (scl_rise_s) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q - 3'd1;
                     if (bit_cnt_q == 3'd0) begin
                        rx_data_q  <= shift_d;
                        rx_valid_q <= 1'b1;
                        ack_q      <= 1'b0;
                        state_q    <= WRITE_ACK;
                     end
                  end
               end
               READ_BYTE: begin
                  if (scl_fall_s) begin
                     if (bit_cnt_q == 3'd0) begin
                        sda_low_q <= 1'b0;
                        ack_q     <= 1'b0;
                        state_q   <= READ_ACK;
                     end else begin
                        shift_q   <= {shift_q[BYTE_W-2:0], 1'b0};
                        sda_low_q <= ~shift_q[BYTE_W-2];
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end
               READ_ACK: begin
                  if (scl_rise_s) begin
                     if (sda_s == I2C_ACK) begin
                        ack_q <= 1'b1;
                     end else begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_STOP;
                     end
                  end else if (scl_fall_s && ack_q) begin
                     tx_req_q  <= 1'b1;
                     shift_q   <= tx_data;
                     sda_low_q <= ~tx_data[BYTE_W-1];
                     bit_cnt_q <= 3'd7;
                     state_q   <= READ_BYTE;
                  end
               end
               WAIT_STOP: begin
                  sda_low_q <= 1'b0;
               end
               default: begin
                  sda_low_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            endcase
         end
      end
   end

   assign sda      = sda_low_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_device.sv
// Bench for i2c_slave_device: bit-banged I2C master, rx/read scoreboard
// queues, and a negedge monitor for rx_valid, tx_req and target SDA drive.
module tb_i2c_slave_device;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_r = 1'b1;
   logic       m_sda_low = 1'b0;
   wire        sda_w;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy;

   logic [7:0] tx_tab [0:7];
   int         tx_cnt = 0;
   int         tgt_low_cnt = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] rx_exp_q [$];
   logic [7:0] rd_exp_q [$];

   pullup (sda_w);
   assign sda_w   = m_sda_low ? 1'b0 : 1'bz;
   assign tx_data = tx_tab[tx_cnt[2:0]];

   always #5 clk = ~clk;

   i2c_slave_device dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl      (scl_r),
      .sda      (sda_w),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy)
   );

   task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         if (rx_exp_q.size() == 0) chk_value("rx_unexpected", 32'd1, 32'd0);
         else chk_value("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
      if (tx_req) tx_cnt++;
      if ((sda_w === 1'b0) && !m_sda_low) tgt_low_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; wait_clk(Q);
      scl_r = 1'b1;     wait_clk(Q);
      m_sda_low = 1'b1; wait_clk(Q);
      scl_r = 1'b0;     wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; wait_clk(Q);
      scl_r = 1'b1;     wait_clk(Q);
      m_sda_low = 1'b0; wait_clk(Q);
   endtask

   task automatic wr_bit(input logic b);
      m_sda_low = ~b; wait_clk(Q);
      scl_r = 1'b1;   wait_clk(2 * Q);
      scl_r = 1'b0;   wait_clk(Q);
   endtask

   task automatic rd_bit(output logic b);
      m_sda_low = 1'b0; wait_clk(Q);
      scl_r = 1'b1;     wait_clk(Q);
      b = sda_w;        wait_clk(Q);
      scl_r = 1'b0;     wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(a);
      chk_value(tag, {31'd0, a}, {31'd0, exp_ack});
   endtask

   task automatic recv_byte(input logic ack, input string tag);
      logic [7:0] d;
      logic       b;
      for (int i = 7; i >= 0; i--) begin
         rd_bit(b);
         d[i] = b;
      end
      wr_bit(ack);
      if (rd_exp_q.size() == 0) chk_value({tag, "_noexp"}, 32'd1, 32'd0);
      else chk_value(tag, {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
   endtask

   initial begin
      int base_tx;
      int base_low;
      tx_tab[0] = 8'h5A; tx_tab[1] = 8'hC3; tx_tab[2] = 8'h2B; tx_tab[3] = 8'hE7;
      tx_tab[4] = 8'h00; tx_tab[5] = 8'h00; tx_tab[6] = 8'h00; tx_tab[7] = 8'h00;
      wait_clk(5);
      chk_value("reset_busy", {31'd0, busy}, 32'd0);
      chk_value("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk_value("reset_sda", {31'd0, sda_w}, 32'd1);
      rst_n = 1'b1;
      wait_clk(5);

      // write to own address
      i2c_start();
      send_byte(8'h84, 1'b0, "wr_addr_ack");
      chk_value("wr_busy", {31'd0, busy}, 32'd1);
      rx_exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b0, "wr_d0_ack");
      rx_exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b0, "wr_d1_ack");
      i2c_stop();
      chk_value("wr_busy_after_stop", {31'd0, busy}, 32'd0);

      // address mismatch
      base_low = tgt_low_cnt;
      i2c_start();
      send_byte(8'h86, 1'b1, "mis_addr_nack");
      chk_value("mis_busy", {31'd0, busy}, 32'd0);
      send_byte(8'hFF, 1'b1, "mis_data_nack");
      i2c_stop();
      chk_value("mis_no_drive", tgt_low_cnt - base_low, 32'd0);

      // read, ACK first byte, NACK second
      base_tx = tx_cnt;
      i2c_start();
      send_byte(8'h85, 1'b0, "rd_addr_ack");
      rd_exp_q.push_back(8'h5A);
      recv_byte(1'b0, "rd_byte0");
      rd_exp_q.push_back(8'hC3);
      recv_byte(1'b1, "rd_byte1");
      chk_value("rd_sda_released", {31'd0, sda_w}, 32'd1);
      chk_value("rd_busy_after_nack", {31'd0, busy}, 32'd0);
      chk_value("rd_tx_req_count", tx_cnt - base_tx, 32'd2);
      wr_bit(1'b1);
      chk_value("rd_wait_stop_quiet", tx_cnt - base_tx, 32'd2);
      i2c_stop();

      // write then repeated START into a read
      base_tx = tx_cnt;
      i2c_start();
      send_byte(8'h84, 1'b0, "rs_addr_w_ack");
      rx_exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b0, "rs_data_ack");
      i2c_start();
      send_byte(8'h85, 1'b0, "rs_addr_r_ack");
      rd_exp_q.push_back(8'h2B);
      recv_byte(1'b1, "rs_rd_byte");
      i2c_stop();
      chk_value("rs_tx_req_count", tx_cnt - base_tx, 32'd1);

      // aborted byte then full write
      i2c_start();
      send_byte(8'h84, 1'b0, "ab_addr_ack");
      for (int i = 0; i < 4; i++) wr_bit(i[0]);
      i2c_stop();
      chk_value("ab_busy", {31'd0, busy}, 32'd0);
      i2c_start();
      send_byte(8'h84, 1'b0, "ab_addr2_ack");
      rx_exp_q.push_back(8'h77);
      send_byte(8'h77, 1'b0, "ab_data_ack");
      i2c_stop();
      chk_value("ab_rx_data_hold", {24'd0, rx_data}, 32'h77);

      // async reset while target drives the address ACK low
      i2c_start();
      for (int i = 7; i >= 0; i--) wr_bit(i == 7 || i == 2);
      m_sda_low = 1'b0;
      chk_value("rst_ack_driven", {31'd0, sda_w}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_value("rst_sda_release", {31'd0, sda_w}, 32'd1);
      chk_value("rst_busy", {31'd0, busy}, 32'd0);
      chk_value("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk_value("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk_value("rst_tx_req", {31'd0, tx_req}, 32'd0);
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
      i2c_stop();
      i2c_start();
      send_byte(8'h84, 1'b0, "post_rst_addr_ack");
      rx_exp_q.push_back(8'h99);
      send_byte(8'h99, 1'b0, "post_rst_data_ack");
      i2c_stop();

      wait_clk(10);
      chk_value("rx_queue_empty", rx_exp_q.size(), 32'd0);
      chk_value("rd_queue_empty", rd_exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_slave_device.md
Name: i2c_slave_device

Overview:
- I2C target (responder) for the I2C bus driven by the team's master device.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a fixed 7-bit address.
- Write transfers: receives bytes and presents them on a parallel port. Read transfers: fetches bytes from the parallel port and shifts them out.
- SDA is open-drain: the block only ever drives 0 or releases to Z. No clock stretching.

Parameters:
- ADDRESS, 7'h42, 7-bit target address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  bus clock from master. Sampled only, never driven.
- sda  inout  1  bus data. Driven 0 when sda_drive_low is set internally, otherwise Z.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse; rx_data is valid on that cycle.
- tx_data  input  8  next byte to send in a read transfer. Sampled on the tx_req cycle.
- tx_req  output  1  one-clk pulse; block latches tx_data this cycle.
- busy  output  1  high from an address-matched START until STOP or NACK-release.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, SDA released (Z), rx_data=0, rx_valid=0, tx_req=0, busy=0.
  - Synchronisers reset to 1 (bus idle).
- Edge detection on synchronised signals:
  - scl_rise/scl_fall: SCL changes.
  - start_det: SDA 1->0 while SCL=1.
  - stop_det: SDA 0->1 while SCL=1.
  - All are registered and valid for one clk.
- Priority: stop_det > start_det > scl edges. Processing must be bounded by SYNC_STAGES+1 clk after the pin change.
- STOP in any state: release SDA, go to IDLE, busy=0.
- START in any state (including repeated START mid-byte): release SDA, bit_cnt=7, go to ADDR.
- States:
  - IDLE: ignore SCL edges; wait for START.
  - ADDR: on each scl_rise, shift SDA into shift_reg and decrement bit_cnt. After the 8th rise (bit_cnt wraps past 0):
    - If shift_reg[7:1]==ADDRESS: latch rw=shift_reg[0], busy=1, go to ADDR_ACK.
    - Otherwise go to IDLE. No ACK is driven on a mismatch.
  - ADDR_ACK: first scl_fall drives SDA low. Second scl_fall, after the master has sampled the ACK:
    - rw=0: release SDA, bit_cnt=7, go to WRITE_BYTE.
    - rw=1: pulse tx_req, load shift_reg<=tx_data the same clk, drive shift_reg[7] (0 drives low, 1 releases), bit_cnt=7, go to READ_BYTE.
  - WRITE_BYTE: shift on scl_rise. After the 8th rise, rx_data<=byte and rx_valid pulses for one clk, then go to WRITE_ACK.
  - WRITE_ACK: same drive/release timing as ADDR_ACK, then back to WRITE_BYTE. The target always ACKs; there is no backpressure.
  - READ_BYTE: on each scl_fall after the first bit, present the next bit MSB-first. After the 8th bit's scl_fall, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on scl_rise.
    - 0 (ACK): on the next scl_fall, tx_req pulse, reload shift_reg, drive MSB, go to READ_BYTE.
    - 1 (NACK): go to WAIT_STOP, SDA released.
  - WAIT_STOP: ignore SCL edges; leave only on STOP or START.
- SDA changes only on scl_fall (or release on START/STOP). It never changes while SCL=1, so the block cannot generate false START/STOP.
- Reset mid-transfer: SDA is released immediately (async). The block is back in IDLE and recovers at the next START.
- A byte that is interrupted (STOP or START before bit 8) produces no rx_valid.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, WRITE_BYTE, WRITE_ACK, READ_BYTE, READ_ACK, WAIT_STOP);
  - I2C_ACK=1'b0, I2C_NACK=1'b1;
  - address width 7, byte width 8.
- One sub-module: i2c_bus_sync. It contains the SYNC_STAGES synchronisers for SCL/SDA and outputs scl_rise, scl_fall, start_det, stop_det. The FSM and shifter stay in the top.

Test Plan:
- Write to own address: START, 0x84 (0x42,W), data 0xA5, 0x3C, STOP -> target ACKs address and both bytes; rx_valid pulses twice with rx_data=0xA5 then 0x3C; busy falls after STOP.
- Address mismatch: START, 0x86 (0x43,W), 0xFF, STOP -> SDA never driven low; no rx_valid; busy stays 0.
- Read with NACK end: START, 0x85, tx_data=0x5A then 0xC3, master ACKs byte 1 and NACKs byte 2 -> master reads 0x5A, 0xC3; exactly two tx_req pulses; SDA released after byte 2; WAIT_STOP until STOP.
- Repeated START: write 0x84, 0x11, then a repeated START, 0x85, read one byte with NACK -> rx_data=0x11 once; tx_req once; no STOP needed between the two phases.
- Aborted byte: START, 0x84, 4 data bits, STOP -> no rx_valid; state IDLE; next full write of 0x77 is received correctly.
- Async reset while the target is driving the ACK low -> SDA goes to Z within the same clk; all outputs are at reset values; next transaction works.
